sram_port_arb: RTL and testbench
================================

# sram_port_arb

Two-requester arbiter for the single-port 1024x8 SRAM in the median filter engine. Shares the one SRAM port between the pixel write path (incoming Din stream stored as line data) and the window read path (columns fetched to feed the 49-entry sorter). Produces registered SRAM controls with active-low enables and returns read data with a fixed-latency valid strobe. Bounds starvation of the losing side with a programmable cap.

## Interface
- AW, 10, SRAM address width
- DW, 8, SRAM data width
- STARVE_MAX, 3, consecutive denied request cycles after which the low-priority side wins one grant (1..15)
- clk  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- PRI  in  1  static priority select: 0 = read side high priority, 1 = write side high priority
- W_REQ  in  1  write request; held until granted
- W_ADDR  in  AW  write address
- W_DATA  in  DW  write data
- W_GNT  out  1  write accepted this cycle (transfer when W_REQ & W_GNT)
- R_REQ  in  1  read request; held until granted
- R_ADDR  in  AW  read address
- R_GNT  out  1  read accepted this cycle
- R_Q  out  DW  read data (registered)
- R_QV  out  1  R_Q valid, one-cycle strobe per accepted read
- A  out  AW  SRAM address (registered)
- D  out  DW  SRAM write data (registered)
- CEN  out  1  SRAM chip enable, active low (registered)
- WEN  out  1  SRAM write enable, active low (registered)
- Q  in  DW  SRAM read data

## Operation
- Clock is clk. Reset is RST: one clock, synchronous, active-high.
- Grants are combinational from REQs, PRI and the arbiter state. At most one grant per cycle. No grant while RST=1.
- Arbiter states:
  - NORMAL: if only one side requests, it is granted. If both request, the PRI-selected side is granted and the loser's starve counter increments.
  - FORCE: entered when the loser's starve counter reaches STARVE_MAX. In FORCE the low-priority side is granted if it still requests. Return to NORMAL next cycle and clear the counter.
  - If the low-priority side drops its request in FORCE, grant normally and return to NORMAL.
- Starve counter: 4 bits. Clears on any grant to the low-priority side and on any cycle the low-priority side does not request. Saturates at STARVE_MAX.
- PRI change: takes effect next cycle. It clears the starve counter and returns the arbiter to NORMAL.
- SRAM drive is registered at the edge ending the grant cycle:
  - Write grant: A=W_ADDR, D=W_DATA, CEN=0, WEN=0.
  - Read grant: A=R_ADDR, CEN=0, WEN=1, D holds its previous value.
  - No grant: CEN=1, WEN=1, A and D hold.
- Read return: a 2-stage valid pipeline tracks reads. R_Q is the registered copy of Q, captured when stage 2 is set. R_QV is asserted with it. R_Q holds its value between strobes.
- Reads and writes complete in grant order. A read granted in the cycle after a write to the same address returns the new data. No bypass is needed.

## Timing
- Reset values: W_GNT=0, R_GNT=0, A=0, D=0, CEN=1, WEN=1, R_Q=0, R_QV=0, starve counter=0, state=NORMAL.
- Grant in cycle N (Gnt·Req) -> SRAM controls valid in cycle N+1 -> SRAM samples at the end of N+1 -> R_Q/R_QV in cycle N+3. Read latency is 3 cycles from grant; sustained throughput is one read per cycle.
- Write latency: the SRAM is written at the end of cycle N+1.
- Back-to-back grants to alternating sides are legal every cycle.
- RST asserted mid-operation: in-flight reads are dropped; R_QV=0 from the cycle after RST is sampled. Registered outputs take reset values at that edge.
- A request deasserted without a grant is legal and has no side effect.

## Test plan
- Reset/idle: RST=1 for 2 cycles, no requests -> CEN=1, WEN=1, A=0, R_QV=0. Both grants stay 0 even with W_REQ=R_REQ=1 during RST.
- Write then read: write 0x5A to 0x123 (cycle 0), read 0x123 (cycle 1) -> WEN=0 at cycle 1 with A=0x123, D=0x5A. R_QV=1 and R_Q=0x5A at cycle 4.
- Streaming reads: R_REQ held 8 cycles over addresses 0..7 preloaded with 0x10..0x17 -> R_QV high cycles 3..10 with R_Q=0x10..0x17 in order.
- Starvation cap: PRI=0, STARVE_MAX=3, both requesting continuously -> grant pattern is R,R,R,W repeating. PRI=1 gives W,W,W,R.
- Reset mid-read: 3 reads granted, RST pulsed in the cycle after the last grant -> no R_QV pulse after RST is sampled; the next read after reset returns correct data at latency 3.
- PRI flip while starving: PRI=0, writer denied 2 cycles, then PRI=1 -> W granted next cycle, starve counter 0, no spurious extra R grant.

Source files
------------

// File: rtl/sram_port_arb.sv
// sram_port_arb: two-requester arbiter for the shared 1024x8 SRAM port.
// It applies static priority with a starvation cap and returns read data with a fixed-latency strobe.
module sram_port_arb #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          PRI,
  input  logic          W_REQ,
  input  logic [AW-1:0] W_ADDR,
  input  logic [DW-1:0] W_DATA,
  output logic          W_GNT,
  input  logic          R_REQ,
  input  logic [AW-1:0] R_ADDR,
  output logic          R_GNT,
  output logic [DW-1:0] R_Q,
  output logic          R_QV,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          CEN,
  output logic          WEN,
  input  logic [DW-1:0] Q
);
  typedef enum logic {NORMAL, FORCE} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic pri_q, hi_req, lo_req, pri_chg, force_lo, gnt_hi, gnt_lo;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d, rq_q;
  logic cen_q, wen_q, v1_q, v2_q, rqv_q;
  always_comb begin
    hi_req = PRI ? W_REQ : R_REQ;
    lo_req = PRI ? R_REQ : W_REQ;
    pri_chg = PRI != pri_q;
    // A priority flip cancels any pending forced grant and arbitrates afresh.
    force_lo = state_q == FORCE && !pri_chg && lo_req;
    gnt_hi = !RST && hi_req && !force_lo;
    gnt_lo = !RST && lo_req && !gnt_hi;
    W_GNT = PRI ? gnt_hi : gnt_lo;
    R_GNT = PRI ? gnt_lo : gnt_hi;
    cnt_d = (pri_chg || !lo_req || gnt_lo) ? 4'd0 : (cnt_q >= SMAX ? SMAX : cnt_q + 4'd1);
    state_d = (state_q == NORMAL && cnt_d == SMAX) ? FORCE : NORMAL;
    a_d = W_GNT ? W_ADDR : (R_GNT ? R_ADDR : a_q);
    d_d = W_GNT ? W_DATA : d_q;
  end
  always_ff @(posedge clk) begin
    pri_q <= PRI;
    if (RST) begin
      state_q <= NORMAL;
      cnt_q <= '0;
      a_q <= '0;
      d_q <= '0;
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      rqv_q <= 1'b0;
      rq_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      d_q <= d_d;
      cen_q <= !(W_GNT || R_GNT);
      wen_q <= !W_GNT;
      v1_q <= R_GNT;
      v2_q <= v1_q;
      rqv_q <= v2_q;
      rq_q <= v2_q ? Q : rq_q;
    end
  end
  assign A = a_q;
  assign D = d_q;
  assign CEN = cen_q;
  assign WEN = wen_q;
  assign R_Q = rq_q;
  assign R_QV = rqv_q;
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: directed bench for sram_port_arb with a behavioural synchronous SRAM.
module tb_sram_port_arb;
  logic clk = 1'b0;
  logic RST, PRI, W_REQ, R_REQ, W_GNT, R_GNT, R_QV, CEN, WEN;
  logic [9:0] W_ADDR, R_ADDR, A;
  logic [7:0] W_DATA, R_Q, D, Q;
  logic [7:0] mem [1024];
  int n_chk = 0;
  int n_err = 0;
  bit done = 1'b0;

  sram_port_arb #(.AW(10), .DW(8), .STARVE_MAX(3)) dut (
    .clk(clk), .RST(RST), .PRI(PRI),
    .W_REQ(W_REQ), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_GNT(W_GNT),
    .R_REQ(R_REQ), .R_ADDR(R_ADDR), .R_GNT(R_GNT), .R_Q(R_Q), .R_QV(R_QV),
    .A(A), .D(D), .CEN(CEN), .WEN(WEN), .Q(Q)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else Q <= mem[A];
    end

  initial begin
    #200000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: test did not complete within the wait limit");
      $finish;
    end
  end

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_chk++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  initial begin
    RST = 1'b1; PRI = 1'b0; W_REQ = 1'b1; R_REQ = 1'b1;
    W_ADDR = '0; R_ADDR = '0; W_DATA = '0;
    @(negedge clk); #1;
    chk("rst_wgnt0", W_GNT, 1'b0);
    chk("rst_rgnt0", R_GNT, 1'b0);
    @(negedge clk); #1;
    chk("rst_wgnt1", W_GNT, 1'b0);
    chk("rst_rgnt1", R_GNT, 1'b0);
    chk("rst_cen", CEN, 1'b1);
    chk("rst_wen", WEN, 1'b1);
    chk("rst_a", A, 10'h000);
    chk("rst_d", D, 8'h00);
    chk("rst_rqv", R_QV, 1'b0);
    chk("rst_rq", R_Q, 8'h00);
    @(negedge clk); RST = 1'b0; W_REQ = 1'b0; R_REQ = 1'b0; #1;
    chk("idle_wgnt", W_GNT, 1'b0);
    chk("idle_rgnt", R_GNT, 1'b0);

    @(negedge clk); W_REQ = 1'b1; W_ADDR = 10'h123; W_DATA = 8'h5A; #1;
    chk("wr_wgnt", W_GNT, 1'b1);
    chk("wr_rgnt", R_GNT, 1'b0);
    @(negedge clk); W_REQ = 1'b0; R_REQ = 1'b1; R_ADDR = 10'h123; #1;
    chk("rd_rgnt", R_GNT, 1'b1);
    chk("wr_cen", CEN, 1'b0);
    chk("wr_wen", WEN, 1'b0);
    chk("wr_a", A, 10'h123);
    chk("wr_d", D, 8'h5A);
    @(negedge clk); R_REQ = 1'b0; #1;
    chk("rd_cen", CEN, 1'b0);
    chk("rd_wen", WEN, 1'b1);
    chk("rd_a", A, 10'h123);
    chk("rd_d_hold", D, 8'h5A);
    @(negedge clk); #1;
    chk("rd_qv_c3", R_QV, 1'b0);
    chk("idle_cen", CEN, 1'b1);
    chk("idle_a_hold", A, 10'h123);
    @(negedge clk); #1;
    chk("rd_qv_c4", R_QV, 1'b1);
    chk("rd_q_c4", R_Q, 8'h5A);
    @(negedge clk); #1;
    chk("rd_qv_c5", R_QV, 1'b0);
    chk("rd_q_hold", R_Q, 8'h5A);

    for (int k = 0; k < 8; k++) begin
      @(negedge clk); W_REQ = 1'b1; W_ADDR = 10'(k); W_DATA = 8'(8'h10 + k); #1;
      chk("pre_wgnt", W_GNT, 1'b1);
    end
    @(negedge clk); W_REQ = 1'b0; #1;

    for (int k = 0; k < 12; k++) begin
      @(negedge clk); R_REQ = (k < 8); R_ADDR = 10'(k); #1;
      n_chk++;
      if (R_GNT !== ((k < 8) ? 1'b1 : 1'b0)) begin
        n_err++;
        $error("FAIL str_rgnt: k=%0d got %0h", k, R_GNT);
      end
      n_chk++;
      if (R_QV !== ((k >= 3 && k <= 10) ? 1'b1 : 1'b0)) begin
        n_err++;
        $error("FAIL str_qv: k=%0d got %0h", k, R_QV);
      end
      if (k >= 3 && k <= 10) begin
        n_chk++;
        if (R_Q !== 8'(8'h10 + k - 3)) begin
          n_err++;
          $error("FAIL str_q: k=%0d got %0h", k, R_Q);
        end
      end
    end

    W_ADDR = 10'h300; W_DATA = 8'hEE; R_ADDR = 10'h000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); W_REQ = 1'b1; R_REQ = 1'b1; #1;
      chk("sv_p0_w", W_GNT, (k % 4 == 3) ? 1'b1 : 1'b0);
      chk("sv_p0_r", R_GNT, (k % 4 == 3) ? 1'b0 : 1'b1);
    end
    @(negedge clk); W_REQ = 1'b0; R_REQ = 1'b0; PRI = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); W_REQ = 1'b1; R_REQ = 1'b1; #1;
      chk("sv_p1_w", W_GNT, (k % 4 == 3) ? 1'b0 : 1'b1);
      chk("sv_p1_r", R_GNT, (k % 4 == 3) ? 1'b1 : 1'b0);
    end

    @(negedge clk); W_REQ = 1'b0; R_REQ = 1'b0; PRI = 1'b0; #1;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); W_REQ = 1'b1; R_REQ = 1'b1; #1;
      chk("flip_pre_r", R_GNT, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); PRI = 1'b1; #1;
      chk("flip_w", W_GNT, (k < 4) ? 1'b1 : 1'b0);
      chk("flip_r", R_GNT, (k < 4) ? 1'b0 : 1'b1);
    end

    @(negedge clk); W_REQ = 1'b0; R_REQ = 1'b0; PRI = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); R_REQ = 1'b1; R_ADDR = 10'(k); #1;
      chk("mr_rgnt", R_GNT, 1'b1);
    end
    @(negedge clk); R_REQ = 1'b0; RST = 1'b1; #1;
    chk("mr_qv_pre", R_QV, 1'b1);
    chk("mr_q_pre", R_Q, 8'h10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); RST = 1'b0; #1;
      chk("mr_qv_drop", R_QV, 1'b0);
      chk("mr_q_rst", R_Q, 8'h00);
      chk("mr_cen", CEN, 1'b1);
    end
    @(negedge clk); R_REQ = 1'b1; R_ADDR = 10'h005; #1;
    chk("post_rgnt", R_GNT, 1'b1);
    @(negedge clk); R_REQ = 1'b0; #1;
    chk("post_qv1", R_QV, 1'b0);
    @(negedge clk); #1;
    chk("post_qv2", R_QV, 1'b0);
    @(negedge clk); #1;
    chk("post_qv3", R_QV, 1'b1);
    chk("post_q3", R_Q, 8'h15);

    done = 1'b1;
    if (n_err != 0) $error("FAIL summary: %0d of %0d checks failed", n_err, n_chk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
